turn_signal_seq: RTL and testbench
==================================

Name: turn_signal_seq

Overview:
- Parametrised successor to the Lab 3 tail-light controller; drives LAMPS lamps per side from switch/button inputs on the DE10-Lite.
- Provides sequential (inner-to-outer sweep) turn signals, synchronous two-side hazard flash and a steady brake overlay.
- Step rate is set by an internal prescaler.
- Sits between the board I/O (SW/KEY synchronised here) and the LEDR lamp mapping in the top level.

Parameters:
- LAMPS, 3: lamps per side (≥2); bit 0 is the innermost lamp.
- TICK_DIV, 2500000: clock cycles per sequence step; 4 Hz at 10 MHz. Benches use 4.
- CW, $clog2(TICK_DIV): prescaler counter width (derived; do not override).

Ports:
- ADC_CLK_10, input, 1: the single system clock.
- KEY0, input, 1: reset. Asynchronous, active-low.
- turn_en, input, 1: turn signals enabled (SW[1]); asynchronous, synchronised internally.
- dir, input, 1: 1 = right, 0 = left (KEY[1]); asynchronous, synchronised internally.
- hazard, input, 1: hazard request (SW[0]); asynchronous, synchronised internally.
- brake, input, 1: brake request; asynchronous, synchronised internally.
- left_lamps, output, LAMPS: left lamp drive, active-high.
- right_lamps, output, LAMPS: right lamp drive, active-high.
- mode, output, 2: current mode (IDLE=0, LEFT=1, RIGHT=2, HAZARD=3).
- step_tick, output, 1: one-cycle pulse on each sequence step.

Behaviour:
- Reset (KEY0=0, any time, including mid-sequence):
  - all synchroniser flops, prescaler and phase = 0; mode = IDLE; all lamp outputs 0; step_tick = 0.
  - Release is synchronous to the next clock edge; operation restarts from phase 0.
- Input synchronisation:
  - Each input passes through 2 flops.
  - An input change seen before edge N is in the mode register at edge N+2.
  - Mode latency is 3 cycles from the input change to the mode/lamp change.
- Mode select from synchronised inputs, priority highest first:
  - hazard=1 → HAZARD
  - else turn_en=1 and dir=1 → RIGHT
  - else turn_en=1 and dir=0 → LEFT
  - else → IDLE
- Mode change: on the edge the mode register changes, the prescaler and phase are both cleared to 0. A mid-sequence direction flip therefore restarts the sweep.
- Prescaler:
  - Counts 0..TICK_DIV-1 and wraps.
  - step_tick=1 for exactly the cycle in which count==TICK_DIV-1.
  - Phase advances on that edge.
  - Counter and phase are held at 0 in IDLE; step_tick stays 0 in IDLE.
- Phase:
  - LEFT/RIGHT: 0..LAMPS, wraps LAMPS→0.
  - HAZARD: toggles 0/1.
- Lamp decode (combinational from registered mode/phase/brake_sync, so glitch-free per cycle):
  - Turning side, phase p: lamps[i] = (i < p). Sequence for LAMPS=3: 000, 001, 011, 111, 000, …
  - Non-turning side: all-ones if brake_sync, else 0.
  - HAZARD: both sides all-ones in phase 0 and 0 in phase 1. Hazard therefore lights immediately on entry. Brake is ignored in HAZARD.
  - IDLE: both sides all-ones if brake_sync, else 0.
- Brake changes never reset the prescaler or phase.
- Simultaneous hazard and turn inputs: hazard wins. Dropping hazard with turn_en still high enters the turn mode at phase 0.

Decomposition:
- Package tsig_pkg holds:
  - mode enum (IDLE, LEFT, RIGHT, HAZARD; 2 bits) and its encodings;
  - default LAMPS and TICK_DIV constants.
- Sub-module tick_prescaler (params TICK_DIV; ports ADC_CLK_10, KEY0, clr, run, tick).
- The 2-flop synchronisers stay inline.

Test Plan (LAMPS=3, TICK_DIV=4, 10 MHz clock):
- Reset: KEY0 low with all inputs high → left/right = 000, mode = 0, step_tick = 0 while low. Releasing KEY0 with inputs low keeps all outputs 0.
- Right turn: turn_en=1, dir=1 → mode=2 after 3 cycles, right = 000. Then right steps 001, 011, 111, 000 every 4 cycles. step_tick is one cycle wide each step; left = 000 throughout.
- Direction flip mid-sweep: at right=011, set dir=0 → 3 cycles later mode=1, right = 000, left = 000. left = 001 exactly 4 cycles after that.
- Hazard priority: hazard=1 during LEFT → 3 cycles later both sides 111, then alternate 000/111 every 4 cycles. Clearing hazard returns to LEFT at left = 000.
- Brake overlay: LEFT with brake=1 → right = 111 steady while left sweeps. IDLE with brake=1 → both 111. Brake toggles do not alter step_tick timing.
- Async reset mid-HAZARD: KEY0 pulsed low for less than 1 cycle between edges → outputs 0 immediately without waiting for a clock edge. After release the sequence restarts from phase 0, with first lamp change 3 cycles later.

Source files
------------

// File: rtl/tsig_pkg.sv
// Shared types and default constants for the sequential turn-signal controller.
package tsig_pkg;

    typedef enum logic [1:0] {
        ModeIdle   = 2'd0,
        ModeLeft   = 2'd1,
        ModeRight  = 2'd2,
        ModeHazard = 2'd3
    } mode_e;

    localparam int unsigned DefLamps   = 3;
    localparam int unsigned DefTickDiv = 2500000;

endpackage

// File: rtl/tick_prescaler.sv
// Step-rate prescaler: counts 0..TICK_DIV-1 while running, pulses tick on the last count.
module tick_prescaler
    import tsig_pkg::*;
#(
    parameter int unsigned TICK_DIV = DefTickDiv,
    parameter int unsigned CW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1
) (
    input  logic ADC_CLK_10,
    input  logic KEY0,
    input  logic clr,
    input  logic run,
    output logic tick
);

    localparam logic [CW-1:0] CountLast = CW'(TICK_DIV - 1);

    logic [CW-1:0] r_count;
    logic          w_last;

    assign w_last = (r_count == CountLast);
    assign tick   = run & w_last;

    always_ff @(posedge ADC_CLK_10 or negedge KEY0) begin
        if (!KEY0) begin
            r_count <= '0;
        end else if (clr || !run || w_last) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + CW'(1);
        end
    end

endmodule

// File: rtl/turn_signal_seq.sv
// Sequential turn signals, hazard flash and brake overlay for LAMPS lamps per side.
module turn_signal_seq
    import tsig_pkg::*;
#(
    parameter int unsigned LAMPS    = DefLamps,
    parameter int unsigned TICK_DIV = DefTickDiv,
    parameter int unsigned CW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1
) (
    input  logic             ADC_CLK_10,
    input  logic             KEY0,
    input  logic             turn_en,
    input  logic             dir,
    input  logic             hazard,
    input  logic             brake,
    output logic [LAMPS-1:0] left_lamps,
    output logic [LAMPS-1:0] right_lamps,
    output logic [1:0]       mode,
    output logic             step_tick
);

    localparam int unsigned   PhaseW    = $clog2(LAMPS + 1);
    localparam logic [PhaseW-1:0] PhaseLast = PhaseW'(LAMPS);

    logic r_turn_s1, r_turn_s2;
    logic r_dir_s1, r_dir_s2;
    logic r_haz_s1, r_haz_s2;
    logic r_brake_s1, r_brake_s2;

    mode_e             r_mode;
    mode_e             w_mode_next;
    logic              w_mode_chg;
    logic              w_run;
    logic              w_tick;
    logic [PhaseW-1:0] r_phase;
    logic [PhaseW-1:0] w_phase_next;
    logic [LAMPS-1:0]  w_sweep;
    logic [LAMPS-1:0]  w_brake_fill;

    always_ff @(posedge ADC_CLK_10 or negedge KEY0) begin
        if (!KEY0) begin
            r_turn_s1  <= 1'b0;
            r_turn_s2  <= 1'b0;
            r_dir_s1   <= 1'b0;
            r_dir_s2   <= 1'b0;
            r_haz_s1   <= 1'b0;
            r_haz_s2   <= 1'b0;
            r_brake_s1 <= 1'b0;
            r_brake_s2 <= 1'b0;
        end else begin
            r_turn_s1  <= turn_en;
            r_turn_s2  <= r_turn_s1;
            r_dir_s1   <= dir;
            r_dir_s2   <= r_dir_s1;
            r_haz_s1   <= hazard;
            r_haz_s2   <= r_haz_s1;
            r_brake_s1 <= brake;
            r_brake_s2 <= r_brake_s1;
        end
    end

    always_comb begin
        w_mode_next = ModeIdle;
        if (r_haz_s2) begin
            w_mode_next = ModeHazard;
        end else if (r_turn_s2) begin
            w_mode_next = r_dir_s2 ? ModeRight : ModeLeft;
        end
    end

    assign w_mode_chg = (w_mode_next != r_mode);
    assign w_run      = (r_mode != ModeIdle);

    tick_prescaler #(
        .TICK_DIV (TICK_DIV),
        .CW       (CW)
    ) u_prescaler (
        .ADC_CLK_10 (ADC_CLK_10),
        .KEY0       (KEY0),
        .clr        (w_mode_chg),
        .run        (w_run),
        .tick       (w_tick)
    );

    // A mode change restarts the sequence, so it takes priority over a coincident tick.
    always_comb begin
        w_phase_next = r_phase;
        if (w_mode_chg || !w_run) begin
            w_phase_next = '0;
        end else if (w_tick) begin
            if (r_mode == ModeHazard) begin
                w_phase_next = (r_phase == '0) ? PhaseW'(1) : '0;
            end else begin
                w_phase_next = (r_phase == PhaseLast) ? '0 : r_phase + PhaseW'(1);
            end
        end
    end

    always_ff @(posedge ADC_CLK_10 or negedge KEY0) begin
        if (!KEY0) begin
            r_mode  <= ModeIdle;
            r_phase <= '0;
        end else begin
            r_mode  <= w_mode_next;
            r_phase <= w_phase_next;
        end
    end

    always_comb begin
        w_sweep = '0;
        for (int unsigned i = 0; i < LAMPS; i++) begin
            w_sweep[i] = (i < 32'(r_phase));
        end
    end

    assign w_brake_fill = r_brake_s2 ? '1 : '0;

    always_comb begin
        left_lamps  = '0;
        right_lamps = '0;
        unique case (r_mode)
            ModeIdle: begin
                left_lamps  = w_brake_fill;
                right_lamps = w_brake_fill;
            end
            ModeLeft: begin
                left_lamps  = w_sweep;
                right_lamps = w_brake_fill;
            end
            ModeRight: begin
                left_lamps  = w_brake_fill;
                right_lamps = w_sweep;
            end
            ModeHazard: begin
                left_lamps  = (r_phase == '0) ? '1 : '0;
                right_lamps = (r_phase == '0) ? '1 : '0;
            end
        endcase
    end

    assign mode      = r_mode;
    assign step_tick = w_tick;

endmodule

// File: tb/tb_turn_signal_seq.sv
// Bench for turn_signal_seq: directed steps plus random input runs against an elapsed-time model.
module tb_turn_signal_seq;

    localparam int LAMPS    = 3;
    localparam int TICK_DIV = 4;

    logic             clk     = 1'b0;
    logic             key0    = 1'b1;
    logic             turn_en = 1'b0;
    logic             dir     = 1'b0;
    logic             hazard  = 1'b0;
    logic             brake   = 1'b0;
    logic [LAMPS-1:0] left_lamps;
    logic [LAMPS-1:0] right_lamps;
    logic [1:0]       mode;
    logic             step_tick;

    int checks = 0;
    int errors = 0;

    // Reference state: 2-deep input delay line, current mode, cycles spent in that mode.
    logic [3:0] m_s1, m_s2;
    int         m_mode;
    int         m_elapsed;

    always #50 clk = ~clk;

    turn_signal_seq #(
        .LAMPS    (LAMPS),
        .TICK_DIV (TICK_DIV)
    ) dut (
        .ADC_CLK_10  (clk),
        .KEY0        (key0),
        .turn_en     (turn_en),
        .dir         (dir),
        .hazard      (hazard),
        .brake       (brake),
        .left_lamps  (left_lamps),
        .right_lamps (right_lamps),
        .mode        (mode),
        .step_tick   (step_tick)
    );

    function automatic int sel_mode(input logic [3:0] s);
        if (s[3]) return 3;
        if (s[2]) return s[1] ? 2 : 1;
        return 0;
    endfunction

    task automatic model_reset();
        m_s1      = '0;
        m_s2      = '0;
        m_mode    = 0;
        m_elapsed = 0;
    endtask

    task automatic model_edge();
        int nm;
        if (!key0) begin
            model_reset();
        end else begin
            nm = sel_mode(m_s2);
            if (nm != m_mode) begin
                m_mode    = nm;
                m_elapsed = 0;
            end else if (m_mode == 0) begin
                m_elapsed = 0;
            end else begin
                m_elapsed++;
            end
            m_s2 = m_s1;
            m_s1 = {hazard, turn_en, dir, brake};
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        int ones, fill, steps, sweep, el, er, et;
        ones  = (1 << LAMPS) - 1;
        fill  = m_s2[0] ? ones : 0;
        steps = m_elapsed / TICK_DIV;
        sweep = (1 << (steps % (LAMPS + 1))) - 1;
        case (m_mode)
            1:       begin el = sweep; er = fill; end
            2:       begin el = fill;  er = sweep; end
            3:       begin el = (steps % 2 == 0) ? ones : 0; er = el; end
            default: begin el = fill;  er = fill; end
        endcase
        et = (m_mode != 0 && (m_elapsed % TICK_DIV) == TICK_DIV - 1) ? 1 : 0;
        check({tag, ".left"},  32'(left_lamps),  32'(el));
        check({tag, ".right"}, 32'(right_lamps), 32'(er));
        check({tag, ".mode"},  32'(mode),        32'(m_mode));
        check({tag, ".tick"},  32'(step_tick),   32'(et));
    endtask

    // Inputs change only at the falling edge, after that cycle's checks.
    task automatic run(input string tag, input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            model_edge();
            @(negedge clk);
            check_all(tag);
        end
    endtask

    initial begin
        model_reset();
        #1 key0 = 1'b0;
        turn_en = 1'b1; dir = 1'b1; hazard = 1'b1; brake = 1'b1;
        run("reset_hold", 4);

        turn_en = 1'b0; dir = 1'b0; hazard = 1'b0; brake = 1'b0;
        key0 = 1'b1;
        run("reset_release", 5);

        turn_en = 1'b1; dir = 1'b1;
        run("right", 12);

        dir = 1'b0;
        run("flip", 14);

        hazard = 1'b1;
        run("hazard", 18);

        hazard = 1'b0;
        run("haz_clear", 10);

        brake = 1'b1;
        run("left_brake", 9);
        brake = 1'b0;
        run("left_brake_off", 5);
        brake = 1'b1;
        run("left_brake_on", 6);

        turn_en = 1'b0;
        run("idle_brake", 6);
        brake = 1'b0;
        run("idle", 4);

        hazard = 1'b1;
        run("haz2", 9);
        // Sub-cycle reset pulse between edges must clear outputs without a clock.
        #10 key0 = 1'b0;
        model_reset();
        #5 check_all("async_rst");
        #10 key0 = 1'b1;
        run("after_rst", 12);

        for (int r = 0; r < 60; r++) begin
            hazard  = ($urandom_range(0, 3) == 0);
            turn_en = $urandom_range(0, 1);
            dir     = $urandom_range(0, 1);
            brake   = $urandom_range(0, 1);
            run("random", $urandom_range(1, 16));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
